// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame scheduler: FSM states, HD44780 command
// bytes and the power-on init list.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SEND,
    GAP,
    IDLE,
    ROW_ADDR,
    ROW_CHAR
  } state_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_ROW0     = 8'h80;
  localparam logic [7:0] LCD_ROW1     = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// Byte-level request/acknowledge bus between the frame scheduler (master)
// and the nibble-level LCD driver (slave).
interface lcd_frame_scheduler_if;
  logic       lcd_req;
  logic       lcd_rs;
  logic [7:0] lcd_byte;
  logic       lcd_ack;

  modport master (output lcd_req, output lcd_rs, output lcd_byte, input lcd_ack);
  modport slave  (input lcd_req, input lcd_rs, input lcd_byte, output lcd_ack);
endinterface

// File: rtl/lcd_frame_buffer.sv
// 2x16 character store with asynchronous read and per-row dirty flags.
// A host write to a row always beats a same-cycle clear of that row.
module lcd_frame_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       clr_en,
  input  logic       clr_row,
  output logic [1:0] dirty
);

  logic [7:0] mem [32];

  // NOTE: the array is reset on purpose so the display starts blank; this
  // forces flops instead of RAM, which is fine at 32 bytes. Sequential state
  // is always assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirty <= 2'b11;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (wr_en && (wr_addr[4] == 1'(r)))     dirty[r] <= 1'b1;
        else if (clr_en && (clr_row == 1'(r)))  dirty[r] <= 1'b0;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Runs the LCD power-on init list, then resends dirty rows of the frame
// buffer one byte at a time over the req/ack bus, pacing each byte with a gap.
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter logic [19:0] PWRON_WAIT = 20'd750000,
  parameter logic [15:0] CMD_GAP    = 16'd2500,
  parameter logic [19:0] CLEAR_GAP  = 20'd100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [4:0]                   wr_addr,
  input  logic [7:0]                   wr_data,
  lcd_frame_scheduler_if.master        lcd,
  output logic                         init_done,
  output logic                         busy
);

  localparam int PWR_N = int'(PWRON_WAIT);
  localparam int CMD_N = int'(CMD_GAP);
  localparam int CLR_N = int'(CLEAR_GAP);
  localparam int MAX_N = (PWR_N > CLR_N) ? ((PWR_N > CMD_N) ? PWR_N : CMD_N)
                                         : ((CLR_N > CMD_N) ? CLR_N : CMD_N);
  localparam int CNT_W = (MAX_N > 2) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_N - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_N - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_N - 1);

  state_t           state, state_next, ret_state, ret_next;
  logic [CNT_W-1:0] cnt, cnt_next, gap_last;
  logic [1:0]       idx, idx_next;
  logic [3:0]       col, col_next;
  logic             row, row_next;
  logic             clear_gap, clear_next;
  logic             req_q, req_next, rs_q, rs_next, done_next;
  logic [7:0]       byte_q, byte_next, send_byte, rd_data;
  logic [1:0]       dirty;
  logic             clr_en;

  lcd_frame_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr ({row, col}),
    .rd_data (rd_data),
    .clr_en  (clr_en),
    .clr_row (row_next),
    .dirty   (dirty)
  );

  always_comb begin
    unique case (state)
      INIT_SEND: send_byte = init_cmd(idx);
      ROW_ADDR:  send_byte = row ? LCD_ROW1 : LCD_ROW0;
      default:   send_byte = rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      ret_state <= INIT_SEND;
      cnt       <= '0;
      idx       <= '0;
      col       <= '0;
      row       <= 1'b0;
      clear_gap <= 1'b0;
      req_q     <= 1'b0;
      rs_q      <= 1'b0;
      byte_q    <= 8'h00;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      ret_state <= ret_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      col       <= col_next;
      row       <= row_next;
      clear_gap <= clear_next;
      req_q     <= req_next;
      rs_q      <= rs_next;
      byte_q    <= byte_next;
      init_done <= done_next;
    end
  end

  // NOTE: every variable written here gets its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ret_next   = ret_state;
    cnt_next   = cnt;
    idx_next   = idx;
    col_next   = col;
    row_next   = row;
    clear_next = clear_gap;
    req_next   = req_q;
    rs_next    = rs_q;
    byte_next  = byte_q;
    done_next  = init_done;
    clr_en     = 1'b0;
    gap_last   = clear_gap ? CLR_LAST : CMD_LAST;

    unique case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_next = INIT_SEND;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      INIT_SEND, ROW_ADDR, ROW_CHAR: begin
        // First cycle in a send state latches the byte; it then holds until ack.
        if (!req_q) begin
          req_next  = 1'b1;
          rs_next   = (state == ROW_CHAR);
          byte_next = send_byte;
        end else if (lcd.lcd_ack) begin
          req_next   = 1'b0;
          state_next = GAP;
          ret_next   = state;
          cnt_next   = '0;
          clear_next = !rs_q && (byte_q == LCD_CLEAR);
        end
      end
      GAP: begin
        if (cnt == gap_last) begin
          cnt_next = '0;
          unique case (ret_state)
            INIT_SEND: begin
              if (idx == 2'd3) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end else begin
                idx_next   = idx + 2'd1;
                state_next = INIT_SEND;
              end
            end
            ROW_ADDR: begin
              col_next   = '0;
              state_next = ROW_CHAR;
            end
            default: begin
              if (col == 4'd15) begin
                state_next = IDLE;
              end else begin
                col_next   = col + 4'd1;
                state_next = ROW_CHAR;
              end
            end
          endcase
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        if (dirty != 2'b00) begin
          state_next = ROW_ADDR;
          row_next   = !dirty[0];
          clr_en     = 1'b1;
        end
      end
      default: state_next = PWR_WAIT;
    endcase
  end

  assign lcd.lcd_req  = req_q;
  assign lcd.lcd_rs   = rs_q;
  assign lcd.lcd_byte = byte_q;
  assign busy         = (state != IDLE);

endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Sequences the character LCD byte driver: runs the power-on init command list, then refreshes a 2x16 character frame buffer onto the display.
- Host logic updates characters with single-cycle writes. The scheduler decides when each row is resent and paces every byte to the driver with a request/acknowledge handshake.
- Sits between application logic (score/status text) and the nibble-level LCD driver.

Parameters:
- PWRON_WAIT, 20'd750000, cycles to wait after reset before the first command (15 ms at 50 MHz).
- CMD_GAP, 16'd2500, idle cycles inserted after every acknowledged byte (50 us).
- CLEAR_GAP, 20'd100000, idle cycles after the clear command 0x01, used instead of CMD_GAP (2 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe, one cycle.
- wr_addr  in  5  character index; [4] = row, [3:0] = column.
- wr_data  in  8  ASCII code.
- lcd_req  out  1  byte request to the driver.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_byte  out  8  byte to send.
- lcd_ack  in  1  one-cycle pulse from the driver when the byte has been sent.
- init_done  out  1  high once the init list completes; stays high until reset.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - outputs: lcd_req=0, lcd_rs=0, lcd_byte=8'h00, init_done=0, busy=1.
  - internals: state=PWR_WAIT, counters=0, frame buffer filled with 8'h20 (space), both row dirty flags=1.
  - Reset mid-transfer drops lcd_req immediately and restarts the full init.
- Frame buffer: 32x8 registers.
  - A write lands on the clock edge where wr_en=1 and sets dirty[wr_addr[4]] on that edge.
  - Writes are accepted in every state, including during init and refresh. No back-pressure.
- States:
  - PWR_WAIT: count to PWRON_WAIT-1, then go to INIT_SEND with init index 0.
  - INIT_SEND: present the init list entry (lcd_rs=0) and assert lcd_req. Init list is 0x28, 0x0C, 0x01, 0x06. On lcd_ack go to GAP.
  - GAP: lcd_req=0; count to CMD_GAP-1, or CLEAR_GAP-1 if the last byte was 0x01. Then return:
    - to INIT_SEND for the next entry;
    - to IDLE after entry 3, with init_done set;
    - to ROW_ADDR or ROW_CHAR depending on the refresh step.
  - IDLE: if dirty[0], refresh row 0; else if dirty[1], refresh row 1; else stay. Row 0 wins when both are dirty.
  - ROW_ADDR: clear dirty[row] on entry, unless a write to the same row occurs that same cycle (write wins, dirty stays 1). Send command 0x80 for row 0 or 0xC0 for row 1, rs=0.
  - ROW_CHAR: send buffer[{row,col}] with rs=1 for col 0..15. After each ack go to GAP. After col 15's gap return to IDLE.
- Handshake rules:
  - lcd_req rises the cycle after entering a send state.
  - lcd_rs and lcd_byte are stable while lcd_req=1.
  - lcd_req falls the cycle after lcd_ack is sampled.
  - lcd_ack while lcd_req=0 is ignored.
  - The character byte is sampled from the buffer when lcd_req rises. A write to that cell during the transfer does not change lcd_byte but leaves the row dirty.
- A write to a row mid-refresh re-sets its dirty flag, so the row is resent after the current pass.
- Counter widths are sized by $clog2 of the largest gap; column counter is 4 bits and wraps exactly at 15.

Decomposition:
- Shared package lcd_pkg:
  - state encodings;
  - command constants LCD_FUNC_SET=8'h28, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY=8'h06, LCD_ROW0=8'h80, LCD_ROW1=8'hC0.
- One sub-module, lcd_frame_buffer: 32x8 register file with a write port, an asynchronous read port and per-row dirty flags with a clear-on-request input.

Test Plan:
- All tests use PWRON_WAIT=10, CMD_GAP=3, CLEAR_GAP=7, and a driver model that acks 2 cycles after lcd_req rises.
- Reset release, no writes:
  - Required: bytes 28, 0C, 01, 06 sent with rs=0.
  - Required: gap after 01 is 7 cycles; init_done then rises.
  - Required: row 0 sent (80 then 16x 20, rs=1), then row 1 (C0 then 16x 20), then busy=0.
- After idle, write addr 5'h13 = 8'h41:
  - Required: only C0 followed by row 1 contents, with byte 4 = 41. No row 0 traffic.
- Same-cycle writes to row 0 and row 1 while idle:
  - Required: row 0 refreshed first, then row 1.
- Write to row 1 col 2 while its col 9 is in flight:
  - Required: current pass completes, then a second full row 1 pass carries the new value.
- Assert rst=0 while lcd_req=1 mid-row:
  - Required: lcd_req=0 and init_done=0 immediately.
  - Required: after release, the sequence restarts at PWR_WAIT and 28 is the first byte.
- Hold lcd_ack high 1 cycle before any request:
  - Required: ignored, with no state advance and no spurious byte.
